delta_channel_scheduler: RTL and testbench
==========================================

// Module: delta_channel_scheduler
// PURPOSE
//  Shares one delta-modulation comparator among NUM_CH sample requesters.
//  A round-robin arbiter grants one pending channel at a time. The block compares the
//  channel's new sample with that channel's stored prev value and its threshold, then
//  emits a 2-bit spike event (bit1 = on, bit0 = off) tagged with the channel index.
//  It sits between the input samplers and the spike output / uo_out packer.
// PARAMETERS
//  NUM_CH  4  number of requesting channels (2..8)
//  DATA_W  4  sample, prev and threshold width in bits
//  CH_W    2  channel index width; must equal clog2(NUM_CH)
// PORTS
//  clk           in   1               system clock
//  reset         in   1               reset, asynchronous, active-high
//  req           in   NUM_CH          per-channel sample pending; held until ack
//  req_data      in   NUM_CH*DATA_W   packed samples; channel i at [i*DATA_W +: DATA_W]
//  req_ack       out  NUM_CH          one-cycle grant/consume pulse, one-hot or zero
//  off_spike_en  in   1               1 = off spikes allowed; 0 = off spikes suppressed
//  cfg_we        in   1               configuration write strobe
//  cfg_sel       in   1               0 = write threshold[cfg_ch]; 1 = force prev[cfg_ch]
//  cfg_ch        in   CH_W            configuration target channel
//  cfg_data      in   DATA_W          configuration value
//  spike_valid   out  1               spike event valid
//  spike_ready   in   1               downstream accepts the event
//  spike         out  2               {on, off}; exactly one bit set while valid
//  spike_ch      out  CH_W            channel the event belongs to
//  busy          out  1               high in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert, release sync to clk):
//   - outputs: req_ack=0, spike_valid=0, spike=2'b00, spike_ch=0, busy=0
//   - all thresholds=0, all prev=0, rr pointer=0, state=IDLE
//   - reset asserted mid-operation aborts the in-flight event; that event is not emitted later.
//  FSM states: IDLE, EVAL, EMIT.
//   - IDLE: if any req bit is set, pick the first set bit scanning from the rr pointer
//     upward (with wrap). Latch channel and sample, and go to EVAL.
//   - EVAL: req_ack[ch]=1 for this cycle only. Register the compare result.
//     If a spike results, go to EMIT; otherwise go to IDLE.
//   - EMIT: spike_valid=1 with spike and spike_ch stable. When spike_ready=1, go to IDLE.
//   - The rr pointer becomes (winner+1) mod NUM_CH on entry to EVAL.
//  Latency: req seen in IDLE at cycle N -> ack at N+1 -> spike_valid at N+2.
//   - Minimum time per event is 3 cycles; a non-spiking sample takes 2 cycles.
//  Compare, in DATA_W+1-bit signed arithmetic: diff = sample - prev[ch].
//   - on  = (diff > 0) && (diff >= threshold[ch])
//   - off = (diff < 0) && (-diff >= threshold[ch]) && off_spike_en
//   - threshold 0 means any nonzero change spikes. diff = 0 never spikes.
//  prev update:
//   - prev[ch] <= sample in the EVAL cycle, only when on or off fires.
//   - A suppressed off spike (off_spike_en=0) leaves prev unchanged.
//  Config writes:
//   - accepted in any state and take effect the next cycle.
//   - same cycle and same channel as an EVAL prev update: the cfg write wins, and the
//     in-flight event is still emitted.
//   - cfg_ch >= NUM_CH: the write is ignored.
//  off_spike_en is sampled in EVAL; changes during EMIT do not alter the pending event.
//  A requester deasserting req before ack is legal; it loses its turn with no ack.
//   - If req drops between IDLE and EVAL, the latched sample is still evaluated.
// STRUCTURE
//  Shared package delta_pkg:
//   - SPIKE_ON = 2'b10, SPIKE_OFF = 2'b01, SPIKE_NONE = 2'b00
//   - FSM state enum sched_state_t
//  Sub-module delta_compare: combinational (sample, prev, threshold, off_en) -> spike[1:0].
//   The same module is reused by the single-channel delta path.
//  Per-channel threshold and prev live in small flop arrays here; no RAM.
// TESTING
//  1. Reset, thr[0]=2, req[0] with sample 5 -> ack[0] at N+1; spike=10, ch=0 at N+2; prev[0]=5.
//  2. prev[1]=9, thr=3, sample 6, off_en=1 -> spike=01; repeat with off_en=0 -> no event, prev stays 9.
//  3. req=4'b1111 held, ready=1 with every sample spiking -> grants 0,1,2,3,0 in order, one ack each.
//  4. Hold spike_ready=0 for 5 cycles in EMIT -> valid, spike and ch stable; no new ack until accepted.
//  5. cfg_sel=1 to the same channel in the same cycle as its EVAL update -> prev = cfg_data; event still emitted.
//  6. Assert reset in EMIT -> valid=0 immediately; after release thr and prev read 0 and no stale event appears.

Source files
------------

// File: rtl/delta_pkg.sv
// Shared definitions for the delta-modulation spike path: spike encodings and scheduler FSM states.
package delta_pkg;

    localparam logic [1:0] SPIKE_ON   = 2'b10;
    localparam logic [1:0] SPIKE_OFF  = 2'b01;
    localparam logic [1:0] SPIKE_NONE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_EMIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/delta_compare.sv
// Combinational delta comparator: signed sample-minus-prev against a per-channel threshold.
module delta_compare
    import delta_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] prev,
    input  logic [DATA_W-1:0] threshold,
    input  logic              off_en,
    output logic [1:0]        spike
);

    localparam logic signed [DATA_W:0] ZERO = '0;

    logic signed [DATA_W:0] diff_s;
    logic signed [DATA_W:0] mag_s;
    logic signed [DATA_W:0] thr_s;

    // One extra bit keeps the full-range difference and its negation representable.
    always_comb begin
        diff_s = $signed({1'b0, sample}) - $signed({1'b0, prev});
        mag_s  = ZERO - diff_s;
        thr_s  = $signed({1'b0, threshold});
        if ((diff_s > ZERO) && (diff_s >= thr_s)) begin
            spike = SPIKE_ON;
        end else if ((diff_s < ZERO) && (mag_s >= thr_s) && off_en) begin
            spike = SPIKE_OFF;
        end else begin
            spike = SPIKE_NONE;
        end
    end

endmodule

// File: rtl/delta_channel_scheduler.sv
// Round-robin scheduler sharing one delta comparator among NUM_CH sample requesters.
module delta_channel_scheduler
    import delta_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4,
    parameter int CH_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ack,
    input  logic                     off_spike_en,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [DATA_W-1:0]        cfg_data,
    output logic                     spike_valid,
    input  logic                     spike_ready,
    output logic [1:0]               spike,
    output logic [CH_W-1:0]          spike_ch,
    output logic                     busy
);

    sched_state_t        state_r;
    sched_state_t        next_state_s;
    logic [CH_W-1:0]     rr_ptr_r;
    logic [CH_W-1:0]     ch_r;
    logic [DATA_W-1:0]   sample_r;
    logic [DATA_W-1:0]   thr_r  [NUM_CH];
    logic [DATA_W-1:0]   prev_r [NUM_CH];
    logic [NUM_CH-1:0]   req_ack_r;
    logic                spike_valid_r;
    logic [1:0]          spike_r;
    logic [CH_W-1:0]     spike_ch_r;
    logic                busy_r;
    logic                found_s;
    logic [CH_W-1:0]     win_s;
    logic [CH_W:0]       idx_s;
    logic [1:0]          cmp_s;
    logic                fire_s;

    delta_compare #(.DATA_W(DATA_W)) u_cmp (
        .sample    (sample_r),
        .prev      (prev_r[ch_r]),
        .threshold (thr_r[ch_r]),
        .off_en    (off_spike_en),
        .spike     (cmp_s)
    );

    assign fire_s = (state_r == ST_EVAL) && (cmp_s != SPIKE_NONE);

    // Round-robin pick: first pending channel at or above the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_s = {1'b0, rr_ptr_r} + (CH_W+1)'(i);
            if (idx_s >= (CH_W+1)'(NUM_CH)) begin
                idx_s = idx_s - (CH_W+1)'(NUM_CH);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s[CH_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[CH_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state decode for the IDLE/EVAL/EMIT sequence.
    always_comb begin
        case (state_r)
            ST_IDLE: next_state_s = found_s ? ST_EVAL : ST_IDLE;
            ST_EVAL: next_state_s = (cmp_s != SPIKE_NONE) ? ST_EMIT : ST_IDLE;
            ST_EMIT: next_state_s = spike_ready ? ST_IDLE : ST_EMIT;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM, latched request and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            ch_r          <= '0;
            sample_r      <= '0;
            req_ack_r     <= '0;
            spike_valid_r <= 1'b0;
            spike_r       <= SPIKE_NONE;
            spike_ch_r    <= '0;
            busy_r        <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            busy_r    <= (next_state_s != ST_IDLE);
            req_ack_r <= '0;
            if ((state_r == ST_IDLE) && found_s) begin
                ch_r      <= win_s;
                sample_r  <= req_data[win_s*DATA_W +: DATA_W];
                req_ack_r <= {{(NUM_CH-1){1'b0}}, 1'b1} << win_s;
                rr_ptr_r  <= (win_s == CH_W'(NUM_CH-1)) ? CH_W'(0) : win_s + CH_W'(1);
            end
            if (fire_s) begin
                spike_valid_r <= 1'b1;
                spike_r       <= cmp_s;
                spike_ch_r    <= ch_r;
            end else if ((state_r == ST_EMIT) && spike_ready) begin
                spike_valid_r <= 1'b0;
                spike_r       <= SPIKE_NONE;
            end
        end
    end

    // Per-channel state; a config write lands after the EVAL update so it wins on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                thr_r[i]  <= {DATA_W{1'b0}};
                prev_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (fire_s) begin
                prev_r[ch_r] <= sample_r;
            end
            if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
                if (cfg_sel) begin
                    prev_r[cfg_ch] <= cfg_data;
                end else begin
                    thr_r[cfg_ch] <= cfg_data;
                end
            end
        end
    end

    assign req_ack     = req_ack_r;
    assign spike_valid = spike_valid_r;
    assign spike       = spike_r;
    assign spike_ch    = spike_ch_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_delta_channel_scheduler.sv
// Directed bench for delta_channel_scheduler with hand-computed expectations.
module tb_delta_channel_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  req_ack;
    logic        off_spike_en;
    logic        cfg_we;
    logic        cfg_sel;
    logic [1:0]  cfg_ch;
    logic [3:0]  cfg_data;
    logic        spike_valid;
    logic        spike_ready;
    logic [1:0]  spike;
    logic [1:0]  spike_ch;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    delta_channel_scheduler #(.NUM_CH(4), .DATA_W(4), .CH_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .off_spike_en (off_spike_en),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_ch       (cfg_ch),
        .cfg_data     (cfg_data),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike        (spike),
        .spike_ch     (spike_ch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_cfg(input logic sel, input logic [1:0] ch, input logic [3:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic set_sample(input int ch, input logic [3:0] val);
        req_data[ch*4 +: 4] = val;
    endtask

    // expected grant order and spike for the all-requesting round
    int         grant_ch  [5] = '{0, 1, 2, 3, 0};
    logic [1:0] grant_spk [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    initial begin
        reset = 1'b1; req = 4'b0000; req_data = 16'h0000; off_spike_en = 1'b1;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = 2'd0; cfg_data = 4'd0; spike_ready = 1'b1;
        step(); step();
        chk("rst_ack", {4'd0, req_ack}, 8'h00);
        chk("rst_valid", {7'd0, spike_valid}, 8'h00);
        chk("rst_spike", {6'd0, spike}, 8'h00);
        chk("rst_ch", {6'd0, spike_ch}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        step();

        // 1: thr0=2, sample 5 -> on spike, ack at N+1, valid at N+2
        set_cfg(1'b0, 2'd0, 4'd2);
        set_sample(0, 4'd5); req = 4'b0001;
        step();
        chk("t1_ack", {4'd0, req_ack}, 8'h01);
        chk("t1_valid_early", {7'd0, spike_valid}, 8'h00);
        chk("t1_busy", {7'd0, busy}, 8'h01);
        req = 4'b0000;
        step();
        chk("t1_valid", {7'd0, spike_valid}, 8'h01);
        chk("t1_spike", {6'd0, spike}, 8'h02);
        chk("t1_ch", {6'd0, spike_ch}, 8'h00);
        chk("t1_ack_off", {4'd0, req_ack}, 8'h00);
        step();
        chk("t1_done_valid", {7'd0, spike_valid}, 8'h00);
        chk("t1_done_busy", {7'd0, busy}, 8'h00);
        // prev0 must now be 5: sample 6 gives diff 1 < thr 2
        set_sample(0, 4'd6); req = 4'b0001;
        step();
        chk("t1_prev_ack", {4'd0, req_ack}, 8'h01);
        req = 4'b0000;
        step();
        chk("t1_prev_nospike", {7'd0, spike_valid}, 8'h00);
        chk("t1_prev_idle", {7'd0, busy}, 8'h00);

        // 2: prev1=9, thr1=3, sample 6 -> off; suppressed when off_en=0
        set_cfg(1'b1, 2'd1, 4'd9);
        set_cfg(1'b0, 2'd1, 4'd3);
        set_sample(1, 4'd6); req = 4'b0010;
        step();
        chk("t2_ack", {4'd0, req_ack}, 8'h02);
        req = 4'b0000;
        step();
        chk("t2_valid", {7'd0, spike_valid}, 8'h01);
        chk("t2_spike", {6'd0, spike}, 8'h01);
        chk("t2_ch", {6'd0, spike_ch}, 8'h01);
        step();
        set_cfg(1'b1, 2'd1, 4'd9);
        off_spike_en = 1'b0; req = 4'b0010;
        step();
        chk("t2_sup_ack", {4'd0, req_ack}, 8'h02);
        req = 4'b0000;
        step();
        chk("t2_sup_valid", {7'd0, spike_valid}, 8'h00);
        chk("t2_sup_busy", {7'd0, busy}, 8'h00);
        off_spike_en = 1'b1; req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        chk("t2_prev_kept", {6'd0, spike}, 8'h01);

        // 3: reset, then all four requesting: round-robin 0,1,2,3,0
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_data = 16'hFFFF; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_ack", {4'd0, req_ack}, 8'(4'b0001 << grant_ch[k]));
            if (k == 0) set_sample(0, 4'd3);
            if (k == 4) req = 4'b0000;
            step();
            chk("t3_valid", {7'd0, spike_valid}, 8'h01);
            chk("t3_ch", {6'd0, spike_ch}, 8'(grant_ch[k]));
            chk("t3_spike", {6'd0, spike}, {6'd0, grant_spk[k]});
            step();
            chk("t3_gap_ack", {4'd0, req_ack}, 8'h00);
        end

        // 4: backpressure, ch2 off spike held for 5 cycles while ch3 waits
        set_sample(2, 4'd5); set_sample(3, 4'd15);
        spike_ready = 1'b0; req = 4'b1100;
        step();
        chk("t4_ack", {4'd0, req_ack}, 8'h04);
        req = 4'b1000;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", {7'd0, spike_valid}, 8'h01);
            chk("t4_hold_spike", {6'd0, spike}, 8'h01);
            chk("t4_hold_ch", {6'd0, spike_ch}, 8'h02);
            chk("t4_hold_ack", {4'd0, req_ack}, 8'h00);
            step();
        end
        spike_ready = 1'b1;
        step();
        chk("t4_accept_valid", {7'd0, spike_valid}, 8'h00);
        step();
        chk("t4_next_ack", {4'd0, req_ack}, 8'h08);
        req = 4'b0000;
        step();
        chk("t4_ch3_nospike", {7'd0, spike_valid}, 8'h00);

        // 5: cfg prev write collides with EVAL update of the same channel
        set_sample(0, 4'd9); req = 4'b0001;
        step();
        chk("t5_ack", {4'd0, req_ack}, 8'h01);
        req = 4'b0000;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_ch = 2'd0; cfg_data = 4'd7;
        step();
        cfg_we = 1'b0;
        chk("t5_valid", {7'd0, spike_valid}, 8'h01);
        chk("t5_spike", {6'd0, spike}, 8'h02);
        step();
        set_sample(0, 4'd7); req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        chk("t5_prev_cfg", {7'd0, spike_valid}, 8'h00);

        // 6: reset during EMIT aborts the event and clears thresholds, prev and pointer
        set_cfg(1'b0, 2'd1, 4'd5);
        set_sample(1, 4'd0); req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        chk("t6_pre_valid", {7'd0, spike_valid}, 8'h01);
        reset = 1'b1;
        #1;
        chk("t6_async_valid", {7'd0, spike_valid}, 8'h00);
        chk("t6_async_busy", {7'd0, busy}, 8'h00);
        step();
        reset = 1'b0;
        step(); step();
        chk("t6_no_stale", {7'd0, spike_valid}, 8'h00);
        set_sample(1, 4'd1); set_sample(3, 4'd0); req = 4'b1010;
        step();
        chk("t6_rr_zero", {4'd0, req_ack}, 8'h02);
        req = 4'b0000;
        step();
        chk("t6_cleared_valid", {7'd0, spike_valid}, 8'h01);
        chk("t6_cleared_spike", {6'd0, spike}, 8'h02);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
